mem_exec_unit: RTL
==================

Name: mem_exec_unit

Overview:
Parametrised successor to the 2-bit-opcode output accumulator. Consumes instruction words (opcode + operand) fetched from the instruction memory over a valid/ready handshake and updates a DATA_W-bit accumulator.
- Adds a wider opcode set, an optional saturating mode and status flags.
- Adds a multi-cycle restoring divider, which stalls the fetch side while it runs.
- Sits between the memory read port and the result display/output stage.

Parameters:
DATA_W, 6, accumulator and operand width (instruction word = 3 + DATA_W bits)
SAT_EN, 1, 1 = ADD/SUB/SHL clamp (unsigned); 0 = wrap modulo 2^DATA_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
instr_valid  input  1  instruction word present on instr
instr  input  3+DATA_W  [DATA_W+2:DATA_W] opcode, [DATA_W-1:0] operand
instr_ready  output  1  unit can accept an instruction this cycle
final_out  output  DATA_W  accumulator value (registered)
rem_out  output  DATA_W  remainder of last DIV (registered)
done  output  1  one-cycle pulse: an instruction retired
flag_zero  output  1  final_out == 0 after last retire
flag_ovf  output  1  last ADD/SUB/SHL overflowed/borrowed (clamped or wrapped)
flag_div0  output  1  last DIV had operand 0

Behaviour:
- Reset (rst=0, async): final_out=0, rem_out=0, done=0, all flags=0, state=IDLE, instr_ready=1. Reset mid-DIV aborts the division with no partial write.
- States:
  - IDLE: instr_ready=1.
  - DIV: instr_ready=0.
- instr_ready is decoded from state (IDLE -> 1), not registered separately.
- Accept on the rising edge with instr_valid & instr_ready. instr is ignored otherwise.
- Opcodes. A = final_out, B = operand.
  - 000 LOAD: A <= B.
  - 001 ADD: A <= A + B. On carry, result is 2^DATA_W-1 if SAT_EN, else the low DATA_W bits. ovf = carry.
  - 010 SUB: A <= A - B. On borrow, result is 0 if SAT_EN, else the wrapped value. ovf = borrow.
  - 011 SHR: A <= A >> 1 (logical). ovf=0.
  - 100 SHL: A <= A << 1. ovf = old MSB. If SAT_EN and MSB=1, result is all ones.
  - 101 DIV: A <= A / B, rem_out <= A % B. Multi-cycle.
  - 110 CLR: A <= 0, rem_out <= 0.
  - 111 NOP: A unchanged.
- Single-cycle ops (all except DIV):
  - final_out and flags update on the accepting edge.
  - done=1 for the next cycle.
  - Back-to-back accepts are allowed every cycle.
- DIV:
  - On the accepting edge (E0), latch dividend=A and divisor=B, and enter DIV.
  - Restoring algorithm, one quotient bit per cycle, exactly DATA_W cycles.
  - At edge E0+DATA_W: write final_out=quotient and rem_out=remainder, set done=1 for the next cycle, return to IDLE with instr_ready=1.
  - final_out holds its old value throughout DIV.
  - Divide by zero still takes DATA_W cycles. Result: quotient = all ones, rem_out = dividend, flag_div0=1.
- Flag updates:
  - flag_ovf is updated only by ADD/SUB/SHL/SHR; held on other ops.
  - flag_div0 is updated only by DIV.
  - flag_zero is updated on every retire, from the new final_out.
- rem_out changes only on DIV and CLR.
- instr_valid high during DIV is not accepted. The source must hold the word until ready (standard valid/ready); the unit never drops a held word.

Test Plan:
- DATA_W=6, SAT_EN=1: LOAD 20, ADD 50 -> final_out=63, flag_ovf=1. Then SUB 63 -> final_out=0, flag_zero=1, flag_ovf=0.
- SAT_EN=0: LOAD 3, SUB 5 -> final_out=62, flag_ovf=1. Then SHL -> final_out=60, flag_ovf=1. Then SHR -> final_out=30, flag_ovf=0.
- LOAD 45, DIV 7 held valid -> instr_ready=0 for 6 cycles, then final_out=6, rem_out=3, done pulses once. The next held instruction is accepted only after ready returns to 1.
- LOAD 9, DIV 0 -> after 6 cycles final_out=63, rem_out=9, flag_div0=1.
- Assert rst low 3 cycles into a DIV -> all outputs 0 immediately. After release, instr_ready=1, and LOAD 5 gives final_out=5.
- Continuous valid stream LOAD 1, ADD 1 ×4, NOP, CLR -> one retire per cycle, final_out sequence 1,2,3,4,5,5,0 and 7 done pulses.

Source files
------------

// File: rtl/mem_exec_unit.sv
// Accumulator execution unit. It accepts opcode+operand words over a valid/ready handshake,
// updates a DATA_W-bit accumulator and raises status flags. DIV runs on a multi-cycle
// restoring divider and stalls the fetch side until it completes.
module mem_exec_unit #(
    parameter int unsigned DATA_W = 6,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [DATA_W+2:0] instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] final_out,
    output logic [DATA_W-1:0] rem_out,
    output logic              done,
    output logic              flag_zero,
    output logic              flag_ovf,
    output logic              flag_div0
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;
    localparam logic [2:0] OpShr  = 3'b011;
    localparam logic [2:0] OpShl  = 3'b100;
    localparam logic [2:0] OpDiv  = 3'b101;
    localparam logic [2:0] OpClr  = 3'b110;
    localparam logic [2:0] OpNop  = 3'b111;

    typedef enum logic [0:0] {StIdle, StDiv} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              div0_q, div0_d;
    // Divider working state: quo_q starts as the dividend and shifts quotient bits in from the
    // bottom; part_q is the partial remainder; dvsr_q the latched divisor.
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] part_q, part_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0]        opcode;
    logic [DATA_W-1:0] operand;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   trial_sub;
    logic              fits;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] part_next;

    assign opcode      = instr[DATA_W+2:DATA_W];
    assign operand     = instr[DATA_W-1:0];
    assign instr_ready = (state_q == StIdle);
    assign final_out   = acc_q;
    assign rem_out     = rem_q;
    assign done        = done_q;
    assign flag_zero   = zero_q;
    assign flag_ovf    = ovf_q;
    assign flag_div0   = div0_q;

    // Arithmetic datapath: single-cycle ALU results and one restoring-divider step.
    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, operand};
        diff      = {1'b0, acc_q} - {1'b0, operand};
        trial     = {part_q, quo_q[DATA_W-1]};
        fits      = (trial >= {1'b0, dvsr_q});
        trial_sub = trial - {1'b0, dvsr_q};
        part_next = fits ? trial_sub[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_next  = (quo_q << 1) | DATA_W'(fits);
    end

    // Next-state: instruction decode in IDLE, divider iteration in DIV.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        div0_d  = div0_q;
        quo_d   = quo_q;
        part_d  = part_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    done_d = 1'b1;
                    case (opcode)
                        OpLoad: acc_d = operand;
                        OpAdd: begin
                            ovf_d = sum[DATA_W];
                            acc_d = (SAT_EN && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
                        end
                        OpSub: begin
                            ovf_d = diff[DATA_W];
                            acc_d = (SAT_EN && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
                        end
                        OpShr: begin
                            ovf_d = 1'b0;
                            acc_d = acc_q >> 1;
                        end
                        OpShl: begin
                            ovf_d = acc_q[DATA_W-1];
                            acc_d = (SAT_EN && acc_q[DATA_W-1]) ? '1 : (acc_q << 1);
                        end
                        OpDiv: begin
                            done_d  = 1'b0;
                            state_d = StDiv;
                            quo_d   = acc_q;
                            part_d  = '0;
                            dvsr_d  = operand;
                            cnt_d   = '0;
                        end
                        OpClr: begin
                            acc_d = '0;
                            rem_d = '0;
                        end
                        OpNop: acc_d = acc_q;
                        default: acc_d = acc_q;
                    endcase
                    // DIV sets flag_zero when it retires, not when it is accepted.
                    if (opcode != OpDiv) begin
                        zero_d = (acc_d == '0);
                    end
                end
            end
            StDiv: begin
                quo_d  = quo_next;
                part_d = part_next;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    // With a zero divisor every step "fits", so the quotient is all ones and
                    // the remainder ends up equal to the dividend.
                    acc_d   = quo_next;
                    rem_d   = part_next;
                    div0_d  = (dvsr_q == '0);
                    zero_d  = (quo_next == '0);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; async reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
            quo_q   <= '0;
            part_q  <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
            quo_q   <= quo_d;
            part_q  <= part_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
